// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that lends one byte-level I2C master to several requesters,
// sequencing address, data and stop phases and reporting status and read data.
module i2c_txn_arbiter #(
   parameter int unsigned REQ_NUM    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BYTES  = 4,
   parameter int unsigned TMO_WIDTH  = 16,
   parameter int unsigned LEN_W      = $clog2(MAX_BYTES + 1),
   parameter int unsigned ID_W       = $clog2(REQ_NUM)
) (
   input  logic                            clk_i,
   input  logic                            a_rst_n_i,
   input  logic [REQ_NUM-1:0]              req_valid_i,
   output logic [REQ_NUM-1:0]              req_ready_o,
   input  logic [REQ_NUM*7-1:0]            req_addr_i,
   input  logic [REQ_NUM-1:0]              req_dir_i,
   input  logic [REQ_NUM*LEN_W-1:0]        req_len_i,
   input  logic [REQ_NUM*MAX_BYTES*DATA_WIDTH-1:0] req_wdata_i,
   input  logic [TMO_WIDTH-1:0]            tmo_i,
   output logic                            rsp_valid_o,
   output logic [ID_W-1:0]                 rsp_id_o,
   output logic [1:0]                      rsp_status_o,
   output logic [MAX_BYTES*DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                            m_en_o,
   output logic [6:0]                      m_addr_o,
   output logic                            m_dir_o,
   output logic [DATA_WIDTH-1:0]           m_data_o,
   output logic                            m_write_o,
   output logic                            m_stop_o,
   input  logic                            m_phase_done_i,
   input  logic                            m_ack_i,
   input  logic [DATA_WIDTH-1:0]           m_rdata_i,
   input  logic                            m_idle_i
);

   localparam int unsigned PAY_W = MAX_BYTES * DATA_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_XFER  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_ANAK = 2'b01;
   localparam logic [1:0] ST_DNAK = 2'b10;
   localparam logic [1:0] ST_TMO  = 2'b11;

   logic [2:0]           r_state, w_state_d;
   logic [ID_W-1:0]      r_rr_ptr, r_id;
   logic [REQ_NUM-1:0]   r_ready;
   logic [6:0]           r_addr;
   logic                 r_dir, r_en;
   logic [LEN_W-1:0]     r_len, r_byte_cnt;
   logic [PAY_W-1:0]     r_wdata, r_rdata;
   logic [1:0]           r_status, r_rsp_status;
   logic                 r_rsp_valid;
   logic [ID_W-1:0]      r_rsp_id;
   logic [TMO_WIDTH-1:0] r_tmo_cnt;

   logic                 w_any;
   logic [ID_W-1:0]      w_gnt, w_gnt_nxt;
   logic [ID_W:0]        w_sum;
   logic [LEN_W-1:0]     w_len_raw;
   logic                 w_cnt_state, w_tmo_hit, w_tmo_exit, w_last;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_sum = '0;
      for (int i = 0; i < int'(REQ_NUM); i++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(REQ_NUM)) w_sum = w_sum - (ID_W+1)'(REQ_NUM);
         if (!w_any && req_valid_i[w_sum[ID_W-1:0]]) begin
            w_any = 1'b1;
            w_gnt = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_gnt_nxt   = (w_gnt == ID_W'(REQ_NUM - 1)) ? '0 : w_gnt + ID_W'(1);
   assign w_len_raw   = req_len_i[LEN_W*w_gnt +: LEN_W];
   assign w_cnt_state = (r_state == S_START) || (r_state == S_ADDR) ||
                        (r_state == S_XFER)  || (r_state == S_STOP);
   // A phase completion in the same cycle beats the timeout.
   assign w_tmo_hit   = w_cnt_state && (tmo_i != '0) && (r_tmo_cnt == tmo_i) &&
                        !m_phase_done_i;
   assign w_last      = (r_byte_cnt == r_len - LEN_W'(1));

   always_comb begin
      w_state_d  = r_state;
      w_tmo_exit = 1'b0;
      case (r_state)
         S_IDLE:  if (w_any) w_state_d = S_START;
         S_START: w_state_d = S_ADDR;
         S_ADDR: begin
            if (m_phase_done_i) w_state_d = (!m_ack_i || r_len == '0) ? S_STOP : S_XFER;
         end
         S_XFER: begin
            if (m_phase_done_i && ((!r_dir && !m_ack_i) || w_last)) w_state_d = S_STOP;
         end
         S_STOP:  if (m_idle_i) w_state_d = S_RESP;
         S_RESP:  w_state_d = S_IDLE;
         default: w_state_d = S_IDLE;
      endcase
      if (w_tmo_hit && !(r_state == S_STOP && m_idle_i)) begin
         w_state_d  = S_RESP;
         w_tmo_exit = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_id         <= '0;
         r_ready      <= '0;
         r_addr       <= '0;
         r_dir        <= 1'b0;
         r_en         <= 1'b0;
         r_len        <= '0;
         r_byte_cnt   <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_status     <= ST_OK;
         r_rsp_status <= ST_OK;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_tmo_cnt    <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ready     <= '0;
         r_rsp_valid <= 1'b0;

         if (w_state_d != r_state || m_phase_done_i) r_tmo_cnt <= '0;
         else if (w_cnt_state)                        r_tmo_cnt <= r_tmo_cnt + TMO_WIDTH'(1);

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_ready    <= REQ_NUM'(1) << w_gnt;
                  r_id       <= w_gnt;
                  r_rr_ptr   <= w_gnt_nxt;
                  r_addr     <= req_addr_i[7*w_gnt +: 7];
                  r_dir      <= req_dir_i[w_gnt];
                  r_len      <= (w_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : w_len_raw;
                  r_wdata    <= req_wdata_i[PAY_W*w_gnt +: PAY_W];
                  r_rdata    <= '0;
                  r_byte_cnt <= '0;
                  r_status   <= ST_OK;
                  r_en       <= 1'b1;
               end
            end
            S_ADDR: begin
               if (m_phase_done_i && !m_ack_i) r_status <= ST_ANAK;
            end
            S_XFER: begin
               if (m_phase_done_i) begin
                  if (r_dir) r_rdata[DATA_WIDTH*r_byte_cnt +: DATA_WIDTH] <= m_rdata_i;
                  if (!r_dir && !m_ack_i) r_status <= ST_DNAK;
                  else                    r_byte_cnt <= r_byte_cnt + LEN_W'(1);
               end
            end
            default: ;
         endcase

         if (w_state_d == S_RESP) begin
            r_en         <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_status <= w_tmo_exit ? ST_TMO : r_status;
         end
      end
   end

   always_comb begin
      m_data_o  = '0;
      m_stop_o  = 1'b0;
      m_write_o = 1'b0;
      if (r_state == S_XFER) begin
         m_data_o  = r_wdata[DATA_WIDTH*r_byte_cnt +: DATA_WIDTH];
         m_stop_o  = w_last;
         m_write_o = !w_last;
      end else if (r_state == S_STOP) begin
         m_stop_o  = 1'b1;
      end
   end

   assign req_ready_o  = r_ready;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_id_o     = r_rsp_id;
   assign rsp_status_o = r_rsp_status;
   assign rsp_rdata_o  = r_rdata;
   assign m_en_o       = r_en;
   assign m_addr_o     = r_addr;
   assign m_dir_o      = r_dir;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: the bench plays the I2C master and checks
// grants, phase sequencing, status codes, read data, timeout and reset.
module tb_i2c_txn_arbiter;
   localparam int REQ_NUM    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BYTES  = 4;
   localparam int TMO_WIDTH  = 16;
   localparam int LEN_W      = 3;
   localparam int ID_W       = 2;

   logic                            clk = 1'b0;
   logic                            rst_n;
   logic [REQ_NUM-1:0]              req_valid;
   logic [REQ_NUM-1:0]              req_ready;
   logic [REQ_NUM*7-1:0]            req_addr;
   logic [REQ_NUM-1:0]              req_dir;
   logic [REQ_NUM*LEN_W-1:0]        req_len;
   logic [REQ_NUM*MAX_BYTES*DATA_WIDTH-1:0] req_wdata;
   logic [TMO_WIDTH-1:0]            tmo;
   logic                            rsp_valid;
   logic [ID_W-1:0]                 rsp_id;
   logic [1:0]                      rsp_status;
   logic [MAX_BYTES*DATA_WIDTH-1:0] rsp_rdata;
   logic                            m_en, m_dir, m_write, m_stop;
   logic [6:0]                      m_addr;
   logic [DATA_WIDTH-1:0]           m_data, m_rdata;
   logic                            m_phase_done, m_ack, m_idle;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(
      .REQ_NUM(REQ_NUM), .DATA_WIDTH(DATA_WIDTH), .MAX_BYTES(MAX_BYTES), .TMO_WIDTH(TMO_WIDTH)
   ) u_dut (
      .clk_i(clk), .a_rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_dir_i(req_dir), .req_len_i(req_len), .req_wdata_i(req_wdata), .tmo_i(tmo),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_status_o(rsp_status),
      .rsp_rdata_o(rsp_rdata), .m_en_o(m_en), .m_addr_o(m_addr), .m_dir_o(m_dir),
      .m_data_o(m_data), .m_write_o(m_write), .m_stop_o(m_stop),
      .m_phase_done_i(m_phase_done), .m_ack_i(m_ack), .m_rdata_i(m_rdata), .m_idle_i(m_idle)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [6:0] a, input logic d,
                          input logic [2:0] len, input logic [31:0] wd);
      req_addr[7*k +: 7]      = a;
      req_dir[k]              = d;
      req_len[LEN_W*k +: LEN_W] = len;
      req_wdata[32*k +: 32]   = wd;
      req_valid[k]            = 1'b1;
   endtask

   // Waits (bounded) for a grant pulse and checks which requester got it.
   task automatic grant(input string tag, input logic [3:0] exp);
      int n = 0;
      tick();
      while (req_ready == '0 && n < 20) begin
         tick();
         n++;
      end
      check(tag, req_ready, exp);
   endtask

   task automatic phase(input logic ack, input logic [7:0] rd);
      m_phase_done = 1'b1;
      m_ack        = ack;
      m_rdata      = rd;
      tick();
      m_phase_done = 1'b0;
      m_ack        = 1'b0;
   endtask

   task automatic end_stop();
      m_idle = 1'b1;
      tick();
      m_idle = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      req_valid = '0; req_addr = '0; req_dir = '0; req_len = '0; req_wdata = '0;
      tmo = '0; m_phase_done = 1'b0; m_ack = 1'b0; m_rdata = '0; m_idle = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst_ready", req_ready, 0);
      check("rst_en",    m_en, 0);
      check("rst_rsp",   {rsp_valid, rsp_id, rsp_status, rsp_rdata}, 0);
      check("rst_m",     {m_addr, m_dir, m_data, m_write, m_stop}, 0);
      do_reset();

      // Single write from requester 2.
      set_req(2, 7'h50, 1'b0, 3'd2, 32'h0000BEEF);
      grant("w_grant", 4'b0100);
      req_valid = '0;
      check("w_en",   m_en, 1);
      check("w_addr", m_addr, 7'h50);
      tick();
      check("w_ready_pulse", req_ready, 0);
      phase(1'b1, 8'h00);
      check("w_b0", {m_data, m_stop, m_write}, {8'hEF, 1'b0, 1'b1});
      phase(1'b1, 8'h00);
      check("w_b1", {m_data, m_stop, m_write}, {8'hBE, 1'b1, 1'b0});
      phase(1'b1, 8'h00);
      check("w_stop", {m_en, m_stop, m_write}, 3'b110);
      end_stop();
      check("w_rsp", {rsp_valid, rsp_id, rsp_status, m_en}, {1'b1, 2'd2, 2'b00, 1'b0});
      tick();
      check("w_rsp_hold", {rsp_valid, rsp_id}, {1'b0, 2'd2});

      // Round-robin from reset with all four requesting.
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, 7'(7'h10 + k), 1'b0, 3'd0, 32'h0);
      for (int r = 0; r < 5; r++) begin
         int e;
         e = r % 4;
         grant($sformatf("rr_grant%0d", r), 4'b0001 << e);
         check($sformatf("rr_addr%0d", r), m_addr, 7'h10 + e);
         tick();
         phase(1'b1, 8'h00);
         end_stop();
         check($sformatf("rr_rsp%0d", r), {rsp_valid, rsp_id, rsp_status}, {1'b1, 2'(e), 2'b00});
         tick();
         check($sformatf("rr_gap%0d", r), req_ready, 0);
      end
      req_valid = '0;

      // Read three bytes from requester 3.
      set_req(3, 7'h48, 1'b1, 3'd3, 32'h0);
      grant("rd_grant", 4'b1000);
      req_valid = '0;
      tick();
      phase(1'b1, 8'h00);
      check("rd_dir", m_dir, 1);
      phase(1'b1, 8'h11);
      phase(1'b1, 8'h22);
      check("rd_last", m_stop, 1);
      phase(1'b1, 8'h33);
      end_stop();
      check("rd_rsp", {rsp_valid, rsp_id, rsp_status}, {1'b1, 2'd3, 2'b00});
      check("rd_data", rsp_rdata, 32'h00332211);
      tick();

      // Address NACK: no data phase, status 01, read data cleared.
      set_req(1, 7'h22, 1'b0, 3'd2, 32'h0000A5A5);
      grant("an_grant", 4'b0010);
      req_valid = '0;
      tick();
      phase(1'b0, 8'h00);
      check("an_stop", {m_stop, m_write}, 2'b10);
      end_stop();
      check("an_rsp", {rsp_valid, rsp_id, rsp_status}, {1'b1, 2'd1, 2'b01});
      check("an_rdata", rsp_rdata, 0);
      tick();

      // Data NACK on byte 1 of a 3-byte write.
      set_req(0, 7'h30, 1'b0, 3'd3, 32'h00CCBBAA);
      grant("dn_grant", 4'b0001);
      req_valid = '0;
      tick();
      phase(1'b1, 8'h00);
      check("dn_b0", m_data, 8'hAA);
      phase(1'b1, 8'h00);
      check("dn_b1", m_data, 8'hBB);
      phase(1'b0, 8'h00);
      check("dn_stop", {m_stop, m_write}, 2'b10);
      end_stop();
      check("dn_rsp", {rsp_valid, rsp_status}, {1'b1, 2'b10});
      tick();

      // Length 7 clamps to 4 bytes.
      set_req(0, 7'h31, 1'b0, 3'd7, 32'h44332211);
      grant("cl_grant", 4'b0001);
      req_valid = '0;
      tick();
      repeat (4) phase(1'b1, 8'h00);
      check("cl_b3", {m_data, m_stop}, {8'h44, 1'b1});
      phase(1'b1, 8'h00);
      check("cl_stop", {m_stop, m_write}, 2'b10);
      end_stop();
      check("cl_rsp", {rsp_valid, rsp_status}, {1'b1, 2'b00});
      tick();

      // Timeout of 20 clocks in ADDR.
      tmo = 16'd20;
      set_req(2, 7'h55, 1'b0, 3'd0, 32'h0);
      grant("to_grant", 4'b0100);
      req_valid = '0;
      tick();
      repeat (20) tick();
      check("to_pre", {rsp_valid, m_en}, 2'b01);
      tick();
      check("to_rsp", {rsp_valid, rsp_id, rsp_status, m_en}, {1'b1, 2'd2, 2'b11, 1'b0});
      tick();

      // Timeout disabled: stays in ADDR indefinitely.
      tmo = '0;
      set_req(1, 7'h56, 1'b0, 3'd0, 32'h0);
      grant("nt_grant", 4'b0010);
      req_valid = '0;
      tick();
      seen = 0;
      repeat (100) begin
         tick();
         if (rsp_valid) seen++;
      end
      check("nt_none", seen, 0);
      check("nt_en", m_en, 1);
      phase(1'b1, 8'h00);
      end_stop();
      check("nt_rsp", {rsp_valid, rsp_status}, {1'b1, 2'b00});
      tick();

      // Asynchronous reset while in XFER.
      set_req(0, 7'h3A, 1'b0, 3'd2, 32'h00001234);
      grant("ar_grant", 4'b0001);
      req_valid = '0;
      tick();
      phase(1'b1, 8'h00);
      check("ar_xfer", {m_data, m_write}, {8'h34, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      check("ar_m", {m_en, m_write, m_stop, m_data, m_addr, m_dir}, 0);
      check("ar_rsp", {rsp_valid, rsp_id, rsp_status, rsp_rdata, req_ready}, 0);
      tick();
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
